pipeline_ctrl: RTL and testbench

Central hazard and redirect controller for the 5-stage RISC-V pipeline. Each cycle it combines the taken-branch signal from EX, load-use hazard detection between ID and EX, and the start/done handshake of the multi-cycle execute unit (mul/div). From these it drives the PC-source select, IF/ID flushes, PC and IF/ID write enables, the ID/EX bubble and the EX hold. It owns the sequencing of multi-cycle redirects and multi-cycle-op stalls.

---
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/redirect controller: branch flush, load-use bubble, mul/div stall.
// Optional perf counters (stall_cnt, flush_cnt) under PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned REDIRECT_HOLD = 1,
  parameter int unsigned PERF_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              mc_start,
  input  logic              mc_done,
  output logic              mux_to_pc,
  output logic              IF_Flush,
  output logic              ID_Flush,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_bubble,
  output logic              ex_stall,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
`endif
  output logic [1:0]        ctrl_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_MCW   = 2'd2
  } state_e;

  localparam logic [2:0] HOLD_RELOAD = 3'(REDIRECT_HOLD - 1);

  state_e     state_q, state_d;
  logic [2:0] hold_q, hold_d;
  logic       load_use;
  logic       mux_c, iff_c, idf_c, pcw_c;
  logic       ifw_c, bub_c, stall_c;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    mux_c   = 1'b0;
    iff_c   = 1'b0;
    idf_c   = 1'b0;
    pcw_c   = 1'b1;
    ifw_c   = 1'b1;
    bub_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        iff_c = 1'b1;
        idf_c = 1'b1;
        if (branch) begin
          mux_c  = 1'b1;
          hold_d = HOLD_RELOAD;
        end else if (hold_q <= 3'd1) begin
          hold_d  = 3'd0;
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - 3'd1;
        end
      end
      ST_MCW: begin
        if (mc_done) begin
          state_d = ST_RUN;
        end else begin
          pcw_c   = 1'b0;
          ifw_c   = 1'b0;
          stall_c = 1'b1;
        end
      end
      default: begin
        // Unused encoding 3 behaves as RUN and returns to it.
        state_d = ST_RUN;
        if (branch) begin
          mux_c = 1'b1;
          iff_c = 1'b1;
          idf_c = 1'b1;
          if (REDIRECT_HOLD > 1) begin
            hold_d  = HOLD_RELOAD;
            state_d = ST_FLUSH;
          end
        end else if (mc_start) begin
          pcw_c   = 1'b0;
          ifw_c   = 1'b0;
          stall_c = 1'b1;
          state_d = ST_MCW;
        end else if (load_use) begin
          pcw_c = 1'b0;
          ifw_c = 1'b0;
          bub_c = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      hold_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign mux_to_pc   = rst_n & mux_c;
  assign IF_Flush    = rst_n & iff_c;
  assign ID_Flush    = rst_n & idf_c;
  assign pc_write    = ~rst_n | pcw_c;
  assign if_id_write = ~rst_n | ifw_c;
  assign id_bubble   = rst_n & bub_c;
  assign ex_stall    = rst_n & stall_c;
  assign ctrl_state  = state_q;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

  logic [PERF_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (stall_q != '1)) stall_q <= stall_q + ONE;
      if (IF_Flush && (flush_q != '1)) flush_q <= flush_q + ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: REDIRECT_HOLD=1 and =3 side by side.
// Counter checks run only when PIPE_CTRL_PERF_EN is defined.
module tb_pipeline_ctrl;

  // {mux_to_pc, IF_Flush, ID_Flush, pc_write, if_id_write, id_bubble, ex_stall}
  localparam int IDLE = 7'b0001100;
  localparam int BRM  = 7'b1111100;
  localparam int FL   = 7'b0111100;
  localparam int LU   = 7'b0000010;
  localparam int MC   = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       branch;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       ex_mem_read, mc_start, mc_done;
  logic [6:0] o1, o3;
  logic [1:0] s1, s3;
`ifdef PIPE_CTRL_PERF_EN
  logic [3:0] sc1, fc1, sc3, fc3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REDIRECT_HOLD(1), .PERF_W(4)) u_h1 (
    .clk(clk), .rst_n(rst_n), .branch(branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mc_start(mc_start), .mc_done(mc_done),
    .mux_to_pc(o1[6]), .IF_Flush(o1[5]), .ID_Flush(o1[4]),
    .pc_write(o1[3]), .if_id_write(o1[2]),
    .id_bubble(o1[1]), .ex_stall(o1[0]),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt(sc1), .flush_cnt(fc1),
`endif
    .ctrl_state(s1)
  );

  pipeline_ctrl #(.REDIRECT_HOLD(3), .PERF_W(4)) u_h3 (
    .clk(clk), .rst_n(rst_n), .branch(branch),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mc_start(mc_start), .mc_done(mc_done),
    .mux_to_pc(o3[6]), .IF_Flush(o3[5]), .ID_Flush(o3[4]),
    .pc_write(o3[3]), .if_id_write(o3[2]),
    .id_bubble(o3[1]), .ex_stall(o3[0]),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt(sc3), .flush_cnt(fc3),
`endif
    .ctrl_state(s3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Sample mid-cycle, then step past the next rising edge; -1 skips an instance.
  task automatic cyc(input string tag, input int e1, input int st1,
                     input int e3, input int st3);
    @(negedge clk);
    if (e1 >= 0) begin
      check({tag, ".h1.out"}, int'(o1), e1);
      check({tag, ".h1.st"}, int'(s1), st1);
    end
    if (e3 >= 0) begin
      check({tag, ".h3.out"}, int'(o3), e3);
      check({tag, ".h3.st"}, int'(s3), st3);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_lu();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; branch = 1'b1;
    mc_start = 1'b0; mc_done = 1'b0;
    clr_lu();

    cyc("rst0", IDLE, 0, IDLE, 0);
    cyc("rst1", IDLE, 0, IDLE, 0);

    rst_n = 1'b1;
    cyc("br0", BRM, 0, BRM, 0);
    branch = 1'b0;
    cyc("br1", IDLE, 0, FL, 1);
    cyc("br2", IDLE, 0, FL, 1);
    cyc("br3", IDLE, 0, IDLE, 0);

    branch = 1'b1;
    cyc("bb0", -1, -1, BRM, 0);
    branch = 1'b0;
    cyc("bb1", -1, -1, FL, 1);
    branch = 1'b1;
    cyc("bb2", BRM, 0, BRM, 1);
    branch = 1'b0;
    cyc("bb3", IDLE, 0, FL, 1);
    cyc("bb4", IDLE, 0, FL, 1);
    cyc("bb5", IDLE, 0, IDLE, 0);

    set_lu();
    cyc("lu", LU, 0, LU, 0);
    clr_lu();
    cyc("lu_end", IDLE, 0, IDLE, 0);
    ex_mem_read = 1'b1; id_uses_rs2 = 1'b1;
    cyc("lu_x0", IDLE, 0, IDLE, 0);
    ex_rd = 5'd6; id_rs2 = 5'd5;
    cyc("lu_diff", IDLE, 0, IDLE, 0);
    ex_rd = 5'd5; id_uses_rs2 = 1'b0;
    cyc("lu_nouse", IDLE, 0, IDLE, 0);
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    cyc("lu_rs1", LU, 0, LU, 0);
    clr_lu();

    mc_start = 1'b1;
    cyc("mc0", MC, 0, MC, 0);
    mc_start = 1'b0;
    cyc("mc1", MC, 2, MC, 2);
    branch = 1'b1;
    cyc("mc2_br", MC, 2, MC, 2);
    branch = 1'b0;
    cyc("mc3", MC, 2, MC, 2);
    mc_done = 1'b1;
    cyc("mc4_done", IDLE, 2, IDLE, 2);
    mc_done = 1'b0;
    cyc("mc5", IDLE, 0, IDLE, 0);

    mc_start = 1'b1; set_lu();
    cyc("mc_ld", MC, 0, MC, 0);
    mc_start = 1'b0; clr_lu(); mc_done = 1'b1;
    cyc("mc_ld_done", IDLE, 2, IDLE, 2);
    mc_done = 1'b0;

    branch = 1'b1; set_lu();
    cyc("br_lu", BRM, 0, BRM, 0);
    branch = 1'b0;
    cyc("br_lu1", LU, 0, FL, 1);
    clr_lu();
    cyc("br_lu2", IDLE, 0, FL, 1);
    cyc("br_lu3", IDLE, 0, IDLE, 0);

    mc_start = 1'b1;
    cyc("rmc0", MC, 0, MC, 0);
    mc_start = 1'b0;
    cyc("rmc1", MC, 2, MC, 2);
    rst_n = 1'b0;
    cyc("rmc_rst", IDLE, 2, IDLE, 2);
    rst_n = 1'b1; mc_done = 1'b1;
    cyc("rmc_late", IDLE, 0, IDLE, 0);
    mc_done = 1'b0;
    cyc("rmc_run", IDLE, 0, IDLE, 0);

    branch = 1'b1;
    cyc("rfl0", BRM, 0, BRM, 0);
    branch = 1'b0; rst_n = 1'b0;
    cyc("rfl_rst", IDLE, 0, IDLE, 1);
    rst_n = 1'b1;
    cyc("rfl_run", IDLE, 0, IDLE, 0);

`ifdef PIPE_CTRL_PERF_EN
    rst_n = 1'b0;
    cyc("p_rst", IDLE, 0, IDLE, 0);
    check("p_rst.sc", int'(sc1), 0);
    check("p_rst.fc", int'(fc3), 0);
    rst_n = 1'b1;
    mc_start = 1'b1;
    cyc("p_mc0", MC, 0, MC, 0);
    mc_start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      cyc("p_mcw", MC, 2, MC, 2);
      if (i == 9) check("p_sc10", int'(sc1), 10);
    end
    check("p_sc_sat", int'(sc1), 15);
    mc_done = 1'b1;
    cyc("p_done", IDLE, 2, IDLE, 2);
    mc_done = 1'b0;
    check("p_sc_hold", int'(sc1), 15);
    rst_n = 1'b0;
    cyc("p_rst2", IDLE, 0, IDLE, 0);
    rst_n = 1'b1; branch = 1'b1;
    cyc("p_br0", BRM, 0, BRM, 0);
    branch = 1'b0;
    cyc("p_br1", IDLE, 0, FL, 1);
    cyc("p_br2", IDLE, 0, FL, 1);
    cyc("p_br3", IDLE, 0, IDLE, 0);
    check("p_fc3", int'(fc3), 3);
    check("p_fc1", int'(fc1), 1);
    check("p_sc_clr", int'(sc3), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
